// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : prefix_adder_pipe
//  Purpose  : Three-stage elastic Brent-Kung prefix adder/subtractor with
//             carry-in, subtract mode and cout/overflow/zero flags.
//             S1 forms group G/P, S2 forms group carries, S3 ripples the sum.
//  Revision : 1.0  initial release
// ============================================================================
module prefix_adder_pipe #(
  parameter int WIDTH     = 64,
  parameter int GROUPSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int C_NGRP = WIDTH / GROUPSIZE;
  localparam int C_LOGN = $clog2(C_NGRP);

  // Stage valid bits
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  // Stage 1 data
  logic [C_NGRP-1:0] s1_g_q, s1_g_d, s1_p_q, s1_p_d;
  logic [WIDTH-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic              s1_c0_q, s1_c0_d;
  // Stage 2 data
  logic [C_NGRP:0]   s2_c_q, s2_c_d;
  logic [WIDTH-1:0]  s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  // Stage 3 (output) data
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  // Combinational helpers
  logic              w_adv1, w_adv2, w_adv3;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0, w_gg, w_gp;
  logic [C_NGRP-1:0] w_grp_g, w_grp_p;
  logic [C_NGRP-1:0] w_pg, w_pp;
  logic [C_NGRP:0]   w_carry;
  logic [WIDTH-1:0]  w_sum;
  logic              w_rc;

  // Elastic advance chain: a stage moves when the one after it moves or it is empty
  always_comb begin
    w_adv3   = out_ready | ~v3_q;
    w_adv2   = w_adv3 | ~v2_q;
    w_adv1   = w_adv2 | ~v1_q;
    in_ready = w_adv1;
  end

  // S1: effective operands and per-group generate/propagate by intra-group lookahead
  always_comb begin
    w_b_eff = sub ? ~b : b;
    w_c0    = sub ? 1'b1 : cin;
    w_grp_g = '0;
    w_grp_p = '0;
    w_gg    = 1'b0;
    w_gp    = 1'b1;
    for (int gi = 0; gi < C_NGRP; gi++) begin
      w_gg = 1'b0;
      w_gp = 1'b1;
      for (int bi = 0; bi < GROUPSIZE; bi++) begin
        w_gg = (a[gi*GROUPSIZE+bi] & w_b_eff[gi*GROUPSIZE+bi]) |
               ((a[gi*GROUPSIZE+bi] ^ w_b_eff[gi*GROUPSIZE+bi]) & w_gg);
        w_gp = w_gp & (a[gi*GROUPSIZE+bi] ^ w_b_eff[gi*GROUPSIZE+bi]);
      end
      w_grp_g[gi] = w_gg;
      w_grp_p[gi] = w_gp;
    end
    v1_d    = w_adv1 ? in_valid : v1_q;
    s1_g_d  = s1_g_q;
    s1_p_d  = s1_p_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_c0_d = s1_c0_q;
    if (w_adv1 && in_valid) begin
      s1_g_d  = w_grp_g;
      s1_p_d  = w_grp_p;
      s1_a_d  = a;
      s1_b_d  = w_b_eff;
      s1_c0_d = w_c0;
    end
  end

  // S2: Brent-Kung up-sweep/down-sweep over group pairs, then fold in c0.
  // In-place update is safe: within one level no updated node is also a source.
  always_comb begin
    w_pg = s1_g_q;
    w_pp = s1_p_q;
    for (int l = 0; l < C_LOGN; l++) begin
      for (int i = 0; i < C_NGRP; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          w_pg[i] = w_pg[i] | (w_pp[i] & w_pg[i - (1 << l)]);
          w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
        end
      end
    end
    for (int l = C_LOGN - 2; l >= 0; l--) begin
      for (int i = 0; i < C_NGRP; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (2 << l))) begin
          w_pg[i] = w_pg[i] | (w_pp[i] & w_pg[i - (1 << l)]);
          w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
        end
      end
    end
    w_carry    = '0;
    w_carry[0] = s1_c0_q;
    for (int i = 1; i <= C_NGRP; i++) begin
      w_carry[i] = w_pg[i-1] | (w_pp[i-1] & s1_c0_q);
    end
    v2_d   = w_adv2 ? v1_q : v2_q;
    s2_c_d = s2_c_q;
    s2_a_d = s2_a_q;
    s2_b_d = s2_b_q;
    if (w_adv2 && v1_q) begin
      s2_c_d = w_carry;
      s2_a_d = s1_a_q;
      s2_b_d = s1_b_q;
    end
  end

  // S3: ripple each group from its registered carry-in and derive the flags
  always_comb begin
    w_sum = '0;
    w_rc  = 1'b0;
    for (int gi = 0; gi < C_NGRP; gi++) begin
      w_rc = s2_c_q[gi];
      for (int bi = 0; bi < GROUPSIZE; bi++) begin
        w_sum[gi*GROUPSIZE+bi] = s2_a_q[gi*GROUPSIZE+bi] ^ s2_b_q[gi*GROUPSIZE+bi] ^ w_rc;
        w_rc = (s2_a_q[gi*GROUPSIZE+bi] & s2_b_q[gi*GROUPSIZE+bi]) |
               ((s2_a_q[gi*GROUPSIZE+bi] ^ s2_b_q[gi*GROUPSIZE+bi]) & w_rc);
      end
    end
    v3_d   = w_adv3 ? v2_q : v3_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (w_adv3 && v2_q) begin
      sum_d  = w_sum;
      cout_d = s2_c_q[C_NGRP];
      ovf_d  = (s2_a_q[WIDTH-1] == s2_b_q[WIDTH-1]) && (w_sum[WIDTH-1] != s2_a_q[WIDTH-1]);
      zero_d = ~|w_sum;
    end
  end

  // Valid bits and visible outputs clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  // Internal data registers are qualified by their valid bits, so need no reset
  always_ff @(posedge clk) begin
    s1_g_q  <= s1_g_d;
    s1_p_q  <= s1_p_d;
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_c0_q <= s1_c0_d;
    s2_c_q  <= s2_c_d;
    s2_a_q  <= s2_a_d;
    s2_b_q  <= s2_b_d;
  end

  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prefix_adder_pipe
//  Purpose  : Self-checking bench: one 64/8 adder plus a 32-bit instance for
//             each group size 1/2/4/8, all fed the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prefix_adder_pipe;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
  } op_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
    logic        e_zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin, sub;
  logic [63:0] a, b;
  logic        in_ready, out_valid, cout, overflow, zero;
  logic [63:0] sum;

  logic [31:0] s32  [4];
  logic        ir32 [4];
  logic        ov32 [4];
  logic        co32 [4];
  logic        of32 [4];
  logic        z32  [4];

  int errors = 0;
  int checks = 0;
  int results = 0;
  op_t q[$];

  always #5 clk = ~clk;

  prefix_adder_pipe #(.WIDTH(64), .GROUPSIZE(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    prefix_adder_pipe #(.WIDTH(32), .GROUPSIZE(1 << gi)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32[gi]),
      .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
      .out_valid(ov32[gi]), .out_ready(out_ready),
      .sum(s32[gi]), .cout(co32[gi]), .overflow(of32[gi]), .zero(z32[gi])
    );
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: plain (w+1)-bit arithmetic on the effective operands
  function automatic res_t model(input op_t op, input int w);
    res_t r;
    logic [64:0] mask, ae, be, t;
    mask   = (65'd1 << w) - 65'd1;
    ae     = {1'b0, op.a} & mask;
    be     = (op.sub ? ~{1'b0, op.b} : {1'b0, op.b}) & mask;
    t      = ae + be + (op.sub ? 65'd1 : {64'd0, op.cin});
    r.sum  = t[63:0] & mask[63:0];
    r.cout = t[w];
    r.ovf  = (ae[w-1] == be[w-1]) && (t[w-1] != ae[w-1]);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  task automatic rand_op();
    a   = {$urandom, $urandom};
    b   = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  // One clock: score the output transfer, record the input transfer, advance
  task automatic do_cycle(output bit accepted);
    op_t  op;
    res_t r, r32;
    #1;
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      check("result_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        op = q.pop_front();
        r  = model(op, 64);
        results++;
        check("sum", sum, r.sum);
        check("cout", 64'(cout), 64'(r.cout));
        check("overflow", 64'(overflow), 64'(r.ovf));
        check("zero", 64'(zero), 64'(r.zero));
        for (int g = 0; g < 4; g++) begin
          r32 = model(op, 32);
          check($sformatf("w32_g%0d_valid", 1 << g), 64'(ov32[g]), 64'd1);
          check($sformatf("w32_g%0d_sum", 1 << g), 64'(s32[g]), r32.sum);
          check($sformatf("w32_g%0d_flags", 1 << g),
                64'({co32[g], of32[g], z32[g]}), 64'({r32.cout, r32.ovf, r32.zero}));
        end
      end
    end else if (out_valid && !out_ready && q.size() != 0) begin
      r = model(q[0], 64);
      check("hold_sum", sum, r.sum);
    end
    if (in_valid && in_ready) begin
      q.push_back('{a: a, b: b, cin: cin, sub: sub});
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() != 0; k++) do_cycle(acc);
    check("drained", 64'(q.size()), 64'd0);
  endtask

  task automatic run_stream(input int n);
    bit acc;
    int drops, start;
    drops = 0;
    start = results;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      rand_op();
      in_valid = 1'b1;
      #0;
      if (!in_ready) drops++;
      do_cycle(acc);
    end
    drain();
    check("stream_in_ready_drops", 64'(drops), 64'd0);
    check("stream_result_count", 64'(results - start), 64'(n));
  endtask

  vec_t vecs[8];

  initial begin
    bit acc;
    int accepts, start, stale;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_sum", sum, 64'd0);
    check("reset_flags", 64'({cout, overflow, zero}), 64'd0);
    check("reset_w32_valid", 64'({ov32[0], ov32[1], ov32[2], ov32[3]}), 64'd0);

    // Directed vectors, one at a time, with latency check
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat_edge1", i), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_lat_edge2", i), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].e_sum);
      check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].e_cout));
      check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].e_ovf));
      check($sformatf("vec%0d_zero", i), 64'(zero), 64'(vecs[i].e_zero));
      @(posedge clk); #1;
      check($sformatf("vec%0d_consumed", i), 64'(out_valid), 64'd0);
    end

    // Back-to-back random stream (64-bit and all 32-bit group sizes)
    run_stream(100);

    // Back-pressure: four offered, three fit, outputs hold
    start = results;
    accepts = 0;
    out_ready = 1'b0;
    rand_op();
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_cycle(acc);
      if (acc) begin
        accepts++;
        rand_op();
      end
    end
    check("bp_accepts", 64'(accepts), 64'd3);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp_full_release_in_ready", 64'(in_ready), 64'd1);
    do_cycle(acc);
    check("bp_fourth_accepted", 64'(acc), 64'd1);
    drain();
    check("bp_result_count", 64'(results - start), 64'd4);

    // Reset with all three stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_op();
      do_cycle(acc);
    end
    check("rst_pipe_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_sum", sum, 64'd0);
    stale = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #0;
      if (out_valid || ov32[0] || ov32[1] || ov32[2] || ov32[3]) stale++;
      do_cycle(acc);
    end
    check("rst_mid_no_stale", 64'(stale), 64'd0);

    // Recovery stream after reset
    run_stream(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
